// File: rtl/spi_byte_rx_fifo.sv
// spi_byte_rx_fifo: oversampled mode-0 SPI slave byte receiver into an RX FIFO with miso probe shifter; define SPI_RX_OVERFLOW_CNT_EN to add overflow_count
module spi_byte_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  input  logic [7:0]                    spi_tx_byte,
  output logic [7:0]                    out_byte,
  output logic                          out_ready,
  input  logic                          next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef SPI_RX_OVERFLOW_CNT_EN
  ,
  output logic [7:0]                    overflow_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0] sck_q, sck_d;
  logic [1:0] cs_q, cs_d, mosi_q, mosi_d, settle_q, settle_d;
  logic cs_prev_q, cs_prev_d, armed_q, armed_d, push_q, push_d, overflow_q, overflow_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic sck_rise, sck_fall, cs_hi, rx_en, rx_bit, tx_load, pop, full, wr_en;
  always_comb begin
    sck_d      = {sck_q[1:0], sck};
    cs_d       = {cs_q[0], cs_n};
    mosi_d     = {mosi_q[0], mosi};
    settle_d   = {settle_q[0], 1'b1};
    cs_prev_d  = cs_q[1];
    sck_rise   = sck_q[1] & ~sck_q[2];
    sck_fall   = ~sck_q[1] & sck_q[2];
    cs_hi      = cs_q[1] & cs_prev_q;
    armed_d    = armed_q | (settle_q[1] & cs_q[1]);
    rx_en      = armed_q & ~cs_hi;
    rx_bit     = rx_en & sck_rise;
    rx_shift_d = rx_bit ? {rx_shift_q[6:0], mosi_q[1]} : rx_shift_q;
    bit_cnt_d  = cs_hi ? 3'd0 : rx_bit ? bit_cnt_q + 3'd1 : bit_cnt_q;
    push_d     = rx_bit & (bit_cnt_q == 3'd7);
    tx_load    = armed_q & ~cs_q[1] & (cs_prev_q | (sck_fall & (bit_cnt_q == 3'd0)));
    tx_shift_d = tx_load ? spi_tx_byte : (sck_fall & ~cs_q[1]) ? {tx_shift_q[6:0], 1'b0} : tx_shift_q;
    miso       = tx_shift_q[7] & ~cs_q[1];
    fifo_level = wr_ptr_q - rd_ptr_q;
    full       = fifo_level[AW];
    out_ready  = |fifo_level;
    pop        = next & out_ready;
    wr_en      = push_q & (~full | pop);
    overflow_d = push_q & full & ~pop;
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
    out_byte   = mem_q[rd_ptr_q[AW-1:0]];
    overflow   = overflow_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q      <= '0;
      cs_q       <= 2'b11;
      mosi_q     <= '0;
      settle_q   <= '0;
      cs_prev_q  <= 1'b1;
      armed_q    <= 1'b0;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      settle_q   <= settle_d;
      cs_prev_q  <= cs_prev_d;
      armed_q    <= armed_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
  end
`ifdef SPI_RX_OVERFLOW_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  always_comb begin
    ovf_cnt_d      = (overflow_d & ~&ovf_cnt_q) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    overflow_count = ovf_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ovf_cnt_q <= '0;
    else ovf_cnt_q <= ovf_cnt_d;
  end
`endif
endmodule

// File: tb/tb_spi_byte_rx_fifo.sv
// tb_spi_byte_rx_fifo: table, directed and randomized checks of spi_byte_rx_fifo against a queue model
module tb_spi_byte_rx_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, next = 1'b0;
  logic miso, out_ready, overflow;
  logic [7:0] spi_tx_byte = 8'h00, out_byte;
  logic [4:0] fifo_level;
`ifdef SPI_RX_OVERFLOW_CNT_EN
  logic [7:0] overflow_count;
`endif
  int n_tests = 0, n_fail = 0, ovf_seen = 0, ovf_exp = 0, ovf_cnt_exp = 0;
  logic [7:0] model_q[$];
  logic [7:0] frame_q[$];
  typedef struct {
    bit         pop;
    logic [7:0] data;
    logic [4:0] lvl;
    logic       rdy;
    logic [7:0] head;
  } vec_t;
  vec_t vecs[6];
  spi_byte_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .spi_tx_byte(spi_tx_byte), .out_byte(out_byte), .out_ready(out_ready), .next(next),
    .fifo_level(fifo_level), .overflow(overflow)
`ifdef SPI_RX_OVERFLOW_CNT_EN
    , .overflow_count(overflow_count)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (overflow) ovf_seen <= ovf_seen + 1;
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else begin
      ovf_exp++;
      ovf_cnt_exp++;
    end
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), model_q.size());
    chk({tag, "_ready"}, 32'(out_ready), 32'(model_q.size() != 0));
    if (model_q.size() != 0) chk({tag, "_head"}, 32'(out_byte), 32'(model_q[0]));
    chk({tag, "_ovf_pulses"}, ovf_seen, ovf_exp);
    chk({tag, "_miso_idle"}, 32'(miso), 0);
`ifdef SPI_RX_OVERFLOW_CNT_EN
    chk({tag, "_ovf_count"}, 32'(overflow_count), ovf_cnt_exp > 255 ? 255 : ovf_cnt_exp);
`endif
  endtask
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (8) @(negedge clk);
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic spi_byte(input logic [7:0] b, input bit pop_last, output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (8) @(negedge clk);
      got[i] = miso;
      sck = 1'b1;
      if (pop_last && i == 0) begin
        repeat (3) @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (4) @(negedge clk);
      end else repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic cs_high();
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] tx);
    logic [7:0] got;
    spi_tx_byte = tx;
    cs_low();
    foreach (frame_q[k]) begin
      spi_byte(frame_q[k], 1'b0, got);
      chk("miso_byte", 32'(got), 32'(tx));
      model_push(frame_q[k]);
    end
    cs_high();
    frame_q.delete();
  endtask
  task automatic do_pop();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask
  initial begin
    int n;
    logic [7:0] got;
    vecs[0] = '{1'b0, 8'hA5, 5'd1, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h00, 5'd0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h11, 5'd1, 1'b1, 8'h11};
    vecs[3] = '{1'b0, 8'h22, 5'd2, 1'b1, 8'h11};
    vecs[4] = '{1'b1, 8'h00, 5'd1, 1'b1, 8'h22};
    vecs[5] = '{1'b1, 8'h00, 5'd0, 1'b0, 8'h00};
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_overflow", 32'(overflow), 0);
    check_state("rst");
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pop) do_pop();
      else begin
        frame_q.push_back(vecs[v].data);
        send_frame(8'hC3);
      end
      chk("vec_level", 32'(fifo_level), 32'(vecs[v].lvl));
      chk("vec_ready", 32'(out_ready), 32'(vecs[v].rdy));
      if (vecs[v].rdy) chk("vec_head", 32'(out_byte), 32'(vecs[v].head));
    end
    frame_q.push_back(8'h11);
    frame_q.push_back(8'h22);
    send_frame(8'h3C);
    chk("duplex_head0", 32'(out_byte), 32'h11);
    do_pop();
    chk("duplex_head1", 32'(out_byte), 32'h22);
    do_pop();
    check_state("duplex");
    spi_tx_byte = 8'h81;
    cs_low();
    spi_bits(8'hFF, 5);
    cs_high();
    frame_q.push_back(8'h7E);
    send_frame(8'h81);
    chk("abort_level", 32'(fifo_level), 1);
    chk("abort_head", 32'(out_byte), 32'h7E);
    do_pop();
    do_pop();
    chk("empty_next_level", 32'(fifo_level), 0);
    chk("empty_next_ready", 32'(out_ready), 0);
    frame_q.push_back(8'h5A);
    send_frame(8'h81);
    chk("after_empty_level", 32'(fifo_level), 1);
    chk("after_empty_head", 32'(out_byte), 32'h5A);
    do_pop();
    check_state("abort");
    for (int i = 0; i < 17; i++) frame_q.push_back(8'(i));
    send_frame(8'h96);
    chk("ovf_level", 32'(fifo_level), 16);
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_head", 32'(out_byte), 0);
`ifdef SPI_RX_OVERFLOW_CNT_EN
    chk("ovf_count", 32'(overflow_count), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      chk("ovf_pop_data", 32'(out_byte), i);
      do_pop();
    end
    check_state("ovf_drained");
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(8'h20 + i));
    send_frame(8'h42);
    check_state("refill");
    spi_tx_byte = 8'h42;
    cs_low();
    spi_byte(8'hEE, 1'b1, got);
    chk("pushpop_miso", 32'(got), 32'h42);
    void'(model_q.pop_front());
    model_push(8'hEE);
    cs_high();
    chk("pushpop_level", 32'(fifo_level), 16);
    chk("pushpop_head", 32'(out_byte), 32'h21);
    check_state("pushpop");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pushpop_tail", 32'(out_byte), 32'hEE);
      check_state("pushpop_drain");
      do_pop();
    end
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) do_pop();
      else begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
        send_frame(8'($urandom));
      end
      check_state("rand");
    end
    while (model_q.size() != 0) do_pop();
    for (int i = 0; i < 3; i++) frame_q.push_back(8'(8'hB0 + i));
    send_frame(8'hFF);
    check_state("pre_reset");
    spi_tx_byte = 8'hFF;
    cs_low();
    spi_bits(8'hA0, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(out_ready), 0);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_miso", 32'(miso), 0);
    reset = 1'b0;
    model_q.delete();
    ovf_cnt_exp = 0;
    spi_bits(8'h00, 5);
    cs_high();
    check_state("post_reset_partial");
    frame_q.push_back(8'h99);
    send_frame(8'h18);
    chk("resume_level", 32'(fifo_level), 1);
    chk("resume_head", 32'(out_byte), 32'h99);
    check_state("resume");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
